vga_fb_writer: RTL and testbench

Write-side companion to the VGA scan-out path: accepts single-pixel writes (x, y, 8-bit RGB) for the 256x192 screen and a whole-screen clear command, and writes them into the frame buffer in main memory through one MCB write port. Pixels in the same 32-bit word are coalesced into a single masked word write; a clear uses 32-word bursts. It sits between the CPU/graphics unit and the memory controller, and the scan-out reader fetches the same frame buffer.

---
 rtl/vga_fb_writer.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_fb_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_writer.sv
// vga_fb_writer
// Write side of the 256x192, 8-bit-per-pixel frame buffer. It accepts single
// pixel writes and a whole-screen clear command, and turns them into MCB
// write-port traffic.
//  - Pixels that fall in the same 32-bit word are coalesced in a holding
//    register. The word is then written once with a byte mask.
//  - A clear fills the screen with 384 bursts of 32 words each.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   calib_done            : memory ready; nothing is accepted while low
//   px_valid/px_ready     : pixel request handshake (px_x, px_y, px_rgb)
//   flush                 : write out a pending partial word
//   clr_start, clr_rgb    : clear request and its colour
//   busy                  : pending word, flush or clear in progress
//   mem_cmd_*             : MCB command port (write only)
//   mem_wr_*              : MCB write-data port (underrun/error unused)
module vga_fb_writer #(
    parameter logic [29:0] FB_BASE = 30'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [7:0]  px_x,
    input  logic [7:0]  px_y,
    input  logic [7:0]  px_rgb,
    input  logic        flush,
    input  logic        clr_start,
    input  logic [7:0]  clr_rgb,
    output logic        busy,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    input  logic        mem_wr_full,
    input  logic        mem_wr_underrun,
    input  logic        mem_wr_error
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_CMD,
        CLR_DATA,
        CLR_CMD
    } state_t;

    localparam logic [8:0] LAST_BURST = 9'd383;
    localparam logic [7:0] SCREEN_H   = 8'd192;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  lane_q, lane_d;
    logic        dirty_q, dirty_d;
    logic        clr_pend_q, clr_pend_d;
    logic [7:0]  clr_rgb_q, clr_rgb_d;
    logic [8:0]  burst_q, burst_d;
    logic [4:0]  word_q, word_d;
    logic        run_q;

    logic [29:0] px_addr;
    logic        px_diff;
    logic        px_fire;
    logic        clr_fire;
    logic        hold_off;

    // The underrun and error flags are only reported by the memory controller.
    // This block does not react to them.
    logic unused_mem_flags;
    assign unused_mem_flags = mem_wr_underrun ^ mem_wr_error;

    assign px_addr  = FB_BASE + {14'd0, px_y, px_x[7:2], 2'b00};
    assign px_diff  = dirty_q && (px_addr != addr_q);
    assign hold_off = px_valid && px_diff;

    // run_q keeps px_ready low while reset is asserted and on the release edge.
    assign px_ready = run_q && calib_done && (state_q == IDLE) && !clr_pend_q
                      && !clr_start && !px_diff;
    assign px_fire  = px_valid && px_ready;
    assign clr_fire = clr_start && run_q && calib_done && (state_q == IDLE)
                      && !clr_pend_q;

    assign busy          = dirty_q || (state_q != IDLE) || clr_pend_q;
    assign mem_cmd_instr = 3'b000;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        data_d            = data_q;
        lane_d            = lane_q;
        dirty_d           = dirty_q;
        clr_pend_d        = clr_pend_q;
        clr_rgb_d         = clr_rgb_q;
        burst_d           = burst_q;
        word_d            = word_q;
        mem_wr_en         = 1'b0;
        mem_wr_data       = 32'd0;
        mem_wr_mask       = 4'b0000;
        mem_cmd_en        = 1'b0;
        mem_cmd_bl        = 6'd0;
        mem_cmd_byte_addr = 30'd0;

        unique case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    clr_pend_d = 1'b0;
                    state_d    = CLR_DATA;
                end else if (clr_fire) begin
                    clr_rgb_d = clr_rgb;
                    burst_d   = 9'd0;
                    word_d    = 5'd0;
                    // A dirty word is written first. The clear waits in
                    // clr_pend with its colour already captured.
                    if (dirty_q) begin
                        clr_pend_d = 1'b1;
                        state_d    = WR_DATA;
                    end else begin
                        state_d = CLR_DATA;
                    end
                end else begin
                    if (px_fire && (px_y < SCREEN_H)) begin
                        if (!dirty_q) begin
                            addr_d = px_addr;
                            data_d = 32'd0;
                            lane_d = 4'b0000;
                        end
                        case (px_x[1:0])
                            2'd0: data_d[7:0]   = px_rgb;
                            2'd1: data_d[15:8]  = px_rgb;
                            2'd2: data_d[23:16] = px_rgb;
                            default: data_d[31:24] = px_rgb;
                        endcase
                        lane_d[px_x[1:0]] = 1'b1;
                        dirty_d           = 1'b1;
                    end
                    // The flush decision uses the merged view. A pixel and
                    // a flush in the same cycle therefore write the merged word.
                    if (dirty_d && ((lane_d == 4'b1111) || hold_off || flush)) begin
                        state_d = WR_DATA;
                    end
                end
            end

            WR_DATA: begin
                mem_wr_data = data_q;
                mem_wr_mask = ~lane_q;
                mem_wr_en   = !mem_wr_full;
                if (!mem_wr_full) begin
                    state_d = WR_CMD;
                end
            end

            WR_CMD: begin
                mem_cmd_en        = !mem_cmd_full;
                mem_cmd_byte_addr = addr_q;
                if (!mem_cmd_full) begin
                    dirty_d = 1'b0;
                    lane_d  = 4'b0000;
                    state_d = IDLE;
                end
            end

            CLR_DATA: begin
                mem_wr_data = {4{clr_rgb_q}};
                mem_wr_en   = !mem_wr_full;
                if (!mem_wr_full) begin
                    word_d = word_q + 5'd1;
                    if (word_q == 5'd31) begin
                        state_d = CLR_CMD;
                    end
                end
            end

            CLR_CMD: begin
                mem_cmd_en        = !mem_cmd_full;
                mem_cmd_bl        = 6'd31;
                mem_cmd_byte_addr = FB_BASE + {14'd0, burst_q, 7'd0};
                if (!mem_cmd_full) begin
                    if (burst_q == LAST_BURST) begin
                        burst_d = 9'd0;
                        state_d = IDLE;
                    end else begin
                        burst_d = burst_q + 9'd1;
                        state_d = CLR_DATA;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= 4'b0000;
            dirty_q    <= 1'b0;
            clr_pend_q <= 1'b0;
            burst_q    <= 9'd0;
            word_q     <= 5'd0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            dirty_q    <= dirty_d;
            clr_pend_q <= clr_pend_d;
            burst_q    <= burst_d;
            word_q     <= word_d;
            run_q      <= 1'b1;
        end
    end

    // The payload registers are only read while the control state marks them
    // valid, so they are not reset.
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        data_q    <= data_d;
        clr_rgb_q <= clr_rgb_d;
    end

endmodule

// File: tb/tb_vga_fb_writer.sv
module tb_vga_fb_writer;
    localparam logic [29:0] BASE = 30'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n, calib_done, px_valid, px_ready, flush, clr_start, busy;
    logic [7:0]  px_x, px_y, px_rgb, clr_rgb;
    logic        mem_cmd_en, mem_cmd_full, mem_wr_en, mem_wr_full;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_underrun, mem_wr_error;

    int checks = 0;
    int errors = 0;

    // Monitor state: every push and every command is logged with its cycle.
    int          cyc = 0;
    int          viol = 0;
    int          fall_cyc = -1;
    logic        busy_prev = 1'b0;
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_mask_q[$];
    int          wr_cyc_q[$];
    logic [29:0] cmd_addr_q[$];
    logic [5:0]  cmd_bl_q[$];
    int          cmd_cyc_q[$];

    always #5 clk = ~clk;

    vga_fb_writer #(.FB_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .px_rgb(px_rgb), .flush(flush), .clr_start(clr_start), .clr_rgb(clr_rgb),
        .busy(busy), .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr),
        .mem_cmd_bl(mem_cmd_bl), .mem_cmd_byte_addr(mem_cmd_byte_addr),
        .mem_cmd_full(mem_cmd_full), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_wr_mask(mem_wr_mask), .mem_wr_full(mem_wr_full),
        .mem_wr_underrun(mem_wr_underrun), .mem_wr_error(mem_wr_error)
    );

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        busy_prev <= busy;
        if (rst_n) begin
            if (mem_wr_en) begin
                wr_data_q.push_back(mem_wr_data);
                wr_mask_q.push_back(mem_wr_mask);
                wr_cyc_q.push_back(cyc);
            end
            if (mem_cmd_en) begin
                cmd_addr_q.push_back(mem_cmd_byte_addr);
                cmd_bl_q.push_back(mem_cmd_bl);
                cmd_cyc_q.push_back(cyc);
            end
            if ((mem_wr_en && mem_wr_full) || (mem_cmd_en && mem_cmd_full) || (mem_cmd_en && mem_cmd_instr != 3'b000))
                viol <= viol + 1;
            if (busy_prev && !busy) fall_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_data_q.delete(); wr_mask_q.delete(); wr_cyc_q.delete();
        cmd_addr_q.delete(); cmd_bl_q.delete(); cmd_cyc_q.delete();
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < bound) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
            n++;
        end
        tick();
    endtask

    task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] rgb, input logic fl);
        px_valid = 1'b1; px_x = x; px_y = y; px_rgb = rgb; flush = fl;
        @(negedge clk);
        checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL px_ready (%0d,%0d): got %b expected 1", x, y, px_ready); end
        tick();
        px_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; calib_done = 1'b1; px_valid = 1'b0; px_x = 0; px_y = 0; px_rgb = 0;
        flush = 1'b0; clr_start = 1'b0; clr_rgb = 0; mem_cmd_full = 1'b0; mem_wr_full = 1'b0;
        mem_wr_underrun = 1'b0; mem_wr_error = 1'b0;
        #22;
        checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL reset_px_ready: got %b expected 0", px_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({mem_wr_en, mem_cmd_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_wr_en, mem_cmd_en}); end
        checks++; if ({mem_wr_data, mem_wr_mask, mem_cmd_byte_addr, mem_cmd_bl} !== 72'd0) begin
            errors++; $display("FAIL reset_buses: got %h/%h/%h/%h expected all 0", mem_wr_data, mem_wr_mask, mem_cmd_byte_addr, mem_cmd_bl);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", px_ready); end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        send_px(8'd5, 8'd0, 8'hAB, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick();
        flush = 1'b0;
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: busy still 1 expected 0"); end
        checks++; if (wr_data_q.size() != 1 || cmd_addr_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d wr %0d cmd expected 1 1", wr_data_q.size(), cmd_addr_q.size());
        end else begin
            checks++; if (wr_data_q[0][15:8] !== 8'hAB || wr_mask_q[0] !== 4'b1101) begin
                errors++; $display("FAIL single_word: got data %h mask %b expected byte1 AB mask 1101", wr_data_q[0], wr_mask_q[0]);
            end
            checks++; if (cmd_addr_q[0] !== BASE + 30'd4 || cmd_bl_q[0] !== 6'd0) begin
                errors++; $display("FAIL single_cmd: got addr %h bl %0d expected %h 0", cmd_addr_q[0], cmd_bl_q[0], BASE + 30'd4);
            end
            checks++; if (cmd_cyc_q[0] <= wr_cyc_q[0]) begin
                errors++; $display("FAIL single_order: got cmd cyc %0d wr cyc %0d expected cmd after wr", cmd_cyc_q[0], wr_cyc_q[0]);
            end
        end
    endtask

    task automatic test_coalesce();
        bit ok;
        clear_logs();
        for (int i = 0; i < 4; i++) send_px(8'(8 + i), 8'd1, 8'(i + 1), 1'b0);
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL coalesce_timeout: busy still 1 expected 0"); end
        checks++; if (wr_data_q.size() != 1 || cmd_addr_q.size() != 1) begin
            errors++; $display("FAIL coalesce_count: got %0d wr %0d cmd expected 1 1", wr_data_q.size(), cmd_addr_q.size());
        end else begin
            checks++; if (wr_data_q[0] !== 32'h04030201 || wr_mask_q[0] !== 4'b0000) begin
                errors++; $display("FAIL coalesce_word: got %h mask %b expected 04030201 0000", wr_data_q[0], wr_mask_q[0]);
            end
            checks++; if (cmd_addr_q[0] !== BASE + 30'd264 || cmd_bl_q[0] !== 6'd0) begin
                errors++; $display("FAIL coalesce_cmd: got addr %h bl %0d expected %h 0", cmd_addr_q[0], cmd_bl_q[0], BASE + 30'd264);
            end
            checks++; if (cmd_cyc_q[0] - wr_cyc_q[0] != 1) begin
                errors++; $display("FAIL coalesce_latency: got %0d expected 1", cmd_cyc_q[0] - wr_cyc_q[0]);
            end
        end
    endtask

    task automatic test_word_change();
        bit ok, acc;
        int low;
        clear_logs();
        send_px(8'd0, 8'd0, 8'h11, 1'b0);
        px_valid = 1'b1; px_x = 8'd4; px_y = 8'd0; px_rgb = 8'h22;
        low = 0; acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (px_ready) acc = 1'b1; else low++;
            tick();
        end
        px_valid = 1'b0;
        checks++; if (!acc || low < 2) begin errors++; $display("FAIL wc_ready_low: got accepted %b low %0d expected 1 and >=2", acc, low); end
        checks++; if (wr_data_q.size() != 1 || cmd_addr_q.size() != 1) begin
            errors++; $display("FAIL wc_flush_first: got %0d wr %0d cmd expected 1 1", wr_data_q.size(), cmd_addr_q.size());
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(20, ok);
        checks++; if (!ok || wr_data_q.size() != 2 || cmd_addr_q.size() != 2) begin
            errors++; $display("FAIL wc_count: got %0d wr %0d cmd expected 2 2", wr_data_q.size(), cmd_addr_q.size());
        end else begin
            checks++; if (wr_mask_q[0] !== 4'b1110 || wr_data_q[0][7:0] !== 8'h11 || cmd_addr_q[0] !== BASE) begin
                errors++; $display("FAIL wc_first: got mask %b data %h addr %h expected 1110 xx11 %h", wr_mask_q[0], wr_data_q[0], cmd_addr_q[0], BASE);
            end
            checks++; if (wr_mask_q[1] !== 4'b1110 || wr_data_q[1][7:0] !== 8'h22 || cmd_addr_q[1] !== BASE + 30'd4) begin
                errors++; $display("FAIL wc_second: got mask %b data %h addr %h expected 1110 xx22 %h", wr_mask_q[1], wr_data_q[1], cmd_addr_q[1], BASE + 30'd4);
            end
        end
    endtask

    task automatic test_merge_flush();
        bit ok;
        clear_logs();
        send_px(8'd20, 8'd5, 8'h55, 1'b0);
        send_px(8'd20, 8'd5, 8'h66, 1'b0);
        send_px(8'd22, 8'd5, 8'h99, 1'b1);
        wait_idle(20, ok);
        checks++; if (!ok || wr_data_q.size() != 1 || cmd_addr_q.size() != 1) begin
            errors++; $display("FAIL merge_count: got %0d wr %0d cmd expected 1 1", wr_data_q.size(), cmd_addr_q.size());
        end else begin
            checks++; if (wr_mask_q[0] !== 4'b1010 || (wr_data_q[0] & 32'h00FF00FF) !== 32'h00990066) begin
                errors++; $display("FAIL merge_word: got data %h mask %b expected xx99xx66 1010", wr_data_q[0], wr_mask_q[0]);
            end
            checks++; if (cmd_addr_q[0] !== BASE + 30'd1300) begin
                errors++; $display("FAIL merge_addr: got %h expected %h", cmd_addr_q[0], BASE + 30'd1300);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        mem_wr_full = 1'b1;
        send_px(8'd1, 8'd2, 8'h3C, 1'b1);
        repeat (10) tick();
        checks++; if (wr_data_q.size() != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_wr_stall: got %0d pushes busy %b expected 0 pushes busy 1", wr_data_q.size(), busy);
        end
        mem_wr_full = 1'b0; mem_cmd_full = 1'b1;
        repeat (11) tick();
        checks++; if (wr_data_q.size() != 1 || cmd_addr_q.size() != 0) begin
            errors++; $display("FAIL bp_cmd_stall: got %0d wr %0d cmd expected 1 0", wr_data_q.size(), cmd_addr_q.size());
        end
        mem_cmd_full = 1'b0;
        wait_idle(20, ok);
        checks++; if (!ok || wr_data_q.size() != 1 || cmd_addr_q.size() != 1) begin
            errors++; $display("FAIL bp_release: got %0d wr %0d cmd expected 1 1", wr_data_q.size(), cmd_addr_q.size());
        end else begin
            checks++; if (wr_mask_q[0] !== 4'b1101 || wr_data_q[0][15:8] !== 8'h3C || cmd_addr_q[0] !== BASE + 30'd512) begin
                errors++; $display("FAIL bp_word: got mask %b data %h addr %h expected 1101 xx3Cxx %h", wr_mask_q[0], wr_data_q[0], cmd_addr_q[0], BASE + 30'd512);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL bp_protocol: got %0d strobes while full expected 0", viol); end
    endtask

    task automatic test_drop_and_calib();
        clear_logs();
        send_px(8'd10, 8'd200, 8'h77, 1'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", busy); end
        tick();
        calib_done = 1'b0; px_valid = 1'b1; px_x = 8'd0; px_y = 8'd0; px_rgb = 8'h01;
        @(negedge clk);
        checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL calib_ready: got %b expected 0", px_ready); end
        tick();
        px_valid = 1'b0; calib_done = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b0 || wr_data_q.size() != 0) begin
            errors++; $display("FAIL drop_writes: got busy %b pushes %0d expected 0 0", busy, wr_data_q.size());
        end
    endtask

    task automatic test_clear();
        bit ok;
        int bad_w, bad_c;
        clear_logs();
        clr_start = 1'b1; clr_rgb = 8'h1C;
        @(negedge clk);
        checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", px_ready); end
        tick();
        clr_start = 1'b0; clr_rgb = 8'hE7;
        wait_idle(14000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_timeout: busy still 1 expected 0"); end
        bad_w = 0; bad_c = 0;
        foreach (wr_data_q[i]) if (wr_data_q[i] !== 32'h1C1C1C1C || wr_mask_q[i] !== 4'b0000) bad_w++;
        foreach (cmd_addr_q[i]) if (cmd_addr_q[i] !== BASE + 30'(i * 128) || cmd_bl_q[i] !== 6'd31) bad_c++;
        checks++; if (wr_data_q.size() != 12288 || bad_w != 0) begin
            errors++; $display("FAIL clr_pushes: got %0d pushes %0d bad expected 12288 0", wr_data_q.size(), bad_w);
        end
        checks++; if (cmd_addr_q.size() != 384 || bad_c != 0) begin
            errors++; $display("FAIL clr_cmds: got %0d cmds %0d bad expected 384 0", cmd_addr_q.size(), bad_c);
        end
        if (cmd_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
            checks++; if (fall_cyc != cmd_cyc_q[cmd_cyc_q.size() - 1] + 1) begin
                errors++; $display("FAIL clr_busy_drop: got cyc %0d expected %0d", fall_cyc, cmd_cyc_q[cmd_cyc_q.size() - 1] + 1);
            end
            checks++; if (fall_cyc - wr_cyc_q[0] != 12672) begin
                errors++; $display("FAIL clr_duration: got %0d expected 12672", fall_cyc - wr_cyc_q[0]);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL clr_protocol: got %0d bad strobes expected 0", viol); end
    endtask

    task automatic test_queued_clear_reset();
        int n;
        clear_logs();
        send_px(8'd3, 8'd3, 8'h10, 1'b0);
        clr_start = 1'b1; clr_rgb = 8'h2D;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL qclr_busy: got %b expected 1", busy); end
        tick();
        clr_start = 1'b0; clr_rgb = 8'hFF;
        n = 0;
        while (cmd_addr_q.size() < 101 && n < 6000) begin tick(); n++; end
        checks++; if (cmd_addr_q.size() < 101) begin
            errors++; $display("FAIL qclr_timeout: got %0d cmds expected 101", cmd_addr_q.size());
        end else begin
            checks++; if (wr_mask_q[0] !== 4'b0111 || wr_data_q[0][31:24] !== 8'h10 || cmd_addr_q[0] !== BASE + 30'd768 || cmd_bl_q[0] !== 6'd0) begin
                errors++; $display("FAIL qclr_pixel: got mask %b data %h addr %h expected 0111 10xxxxxx %h", wr_mask_q[0], wr_data_q[0], cmd_addr_q[0], BASE + 30'd768);
            end
            checks++; if (wr_data_q[1] !== 32'h2D2D2D2D || cmd_addr_q[1] !== BASE || cmd_addr_q[100] !== BASE + 30'd12672 || cmd_bl_q[100] !== 6'd31) begin
                errors++; $display("FAIL qclr_bursts: got data %h addr1 %h addr100 %h bl %0d", wr_data_q[1], cmd_addr_q[1], cmd_addr_q[100], cmd_bl_q[100]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({px_ready, busy, mem_wr_en, mem_cmd_en} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_ctrl: got %b expected 0000", {px_ready, busy, mem_wr_en, mem_cmd_en});
        end
        checks++; if ({mem_wr_data, mem_wr_mask, mem_cmd_byte_addr, mem_cmd_bl} !== 72'd0) begin
            errors++; $display("FAIL mid_reset_buses: got %h/%h/%h/%h expected all 0", mem_wr_data, mem_wr_mask, mem_cmd_byte_addr, mem_cmd_bl);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (px_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL after_reset: got ready %b busy %b expected 1 0", px_ready, busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_coalesce();
        test_word_change();
        test_merge_flush();
        test_backpressure();
        test_drop_and_calib();
        test_clear();
        test_queued_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
